// File: rtl/bcd_scan_display.sv
// Four-digit multiplexed 7-segment driver with a shadow register, leading-zero
// blanking, and a one-cycle blank between digit slots to suppress ghosting.
module bcd_scan_display #(
   parameter int unsigned TICK_DIV = 50000,
   parameter int unsigned PRE_W    = 16
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        load_i,
   input  logic [15:0] bcd_in_i,
   input  logic [3:0]  dp_in_i,
   input  logic        blank_lz_i,
   input  logic        enable_i,
   output logic [6:0]  seg_o,
   output logic        dp_o,
   output logic [3:0]  an_o,
   output logic        digit_err_o
);

   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

   logic [15:0]      digits_q;
   logic [3:0]       dps_q;
   logic             blz_q;
   logic             err_q, err_d;
   logic [PRE_W-1:0] pre_q, pre_d;
   logic [1:0]       idx_q, idx_d;
   logic [6:0]       seg_q, seg_d;
   logic             dp_q, dp_d;
   logic [3:0]       an_q, an_d;
   logic [3:0]       nib;
   logic             blank;

   function automatic logic [6:0] seg_decode(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'd0:    s = 7'b0111111;
         4'd1:    s = 7'b0000110;
         4'd2:    s = 7'b1011011;
         4'd3:    s = 7'b1001111;
         4'd4:    s = 7'b1100110;
         4'd5:    s = 7'b1101101;
         4'd6:    s = 7'b1111101;
         4'd7:    s = 7'b0000111;
         4'd8:    s = 7'b1111111;
         4'd9:    s = 7'b1101111;
         default: s = 7'b1111001;
      endcase
      return s;
   endfunction

   always_comb begin
      pre_d = pre_q;
      idx_d = idx_q;
      if (enable_i) begin
         if (pre_q == PRE_LAST) begin
            pre_d = '0;
            idx_d = idx_q + 2'd1;
         end else begin
            pre_d = pre_q + PRE_W'(1);
         end
      end
   end

   // A digit is blanked only if it and every more significant digit are zero.
   always_comb begin
      nib = digits_q[{idx_q, 2'b00} +: 4];
      case (idx_q)
         2'd3:    blank = blz_q && (digits_q[15:12] == 4'd0);
         2'd2:    blank = blz_q && (digits_q[15:8] == 8'd0);
         2'd1:    blank = blz_q && (digits_q[15:4] == 12'd0);
         default: blank = 1'b0;
      endcase
   end

   always_comb begin
      if (pre_q == '0) begin
         an_d  = 4'b1111;
         seg_d = 7'b0000000;
         dp_d  = 1'b0;
      end else begin
         an_d  = ~(4'b0001 << idx_q);
         seg_d = blank ? 7'b0000000 : seg_decode(nib);
         dp_d  = dps_q[idx_q];
      end
   end

   always_comb begin
      err_d = err_q;
      if (load_i) begin
         err_d = (bcd_in_i[3:0]   > 4'd9) || (bcd_in_i[7:4]   > 4'd9) ||
                 (bcd_in_i[11:8]  > 4'd9) || (bcd_in_i[15:12] > 4'd9);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         digits_q <= '0;
         dps_q    <= '0;
         blz_q    <= 1'b0;
         err_q    <= 1'b0;
         pre_q    <= '0;
         idx_q    <= '0;
         seg_q    <= '0;
         dp_q     <= 1'b0;
         an_q     <= 4'b1111;
      end else begin
         if (load_i) begin
            digits_q <= bcd_in_i;
            dps_q    <= dp_in_i;
            blz_q    <= blank_lz_i;
         end
         err_q <= err_d;
         pre_q <= pre_d;
         idx_q <= idx_d;
         seg_q <= seg_d;
         dp_q  <= dp_d;
         an_q  <= an_d;
      end
   end

   assign seg_o       = seg_q;
   assign dp_o        = dp_q;
   assign an_o        = an_q;
   assign digit_err_o = err_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Bench for bcd_scan_display at TICK_DIV=4: a cycle model pushes expected
// {an,seg,dp,err} per rising edge; scenario tasks pop and compare on falling edges.
module tb_bcd_scan_display;

   localparam int TICK_DIV = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        load = 1'b0;
   logic [15:0] bcd = '0;
   logic [3:0]  dpi = '0;
   logic        blz = 1'b0;
   logic        en = 1'b0;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;
   logic        err;

   int n_checks = 0;
   int n_errors = 0;

   logic [12:0] exp_q[$];

   logic [6:0] seg_tbl [16] = '{
      7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
      7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111,
      7'b1111001, 7'b1111001, 7'b1111001, 7'b1111001, 7'b1111001, 7'b1111001};

   int         m_pre = 0;
   int         m_idx = 0;
   logic [3:0] m_dig [4] = '{4'd0, 4'd0, 4'd0, 4'd0};
   logic [3:0] m_dp = '0;
   logic       m_blz = 1'b0;
   logic       m_err = 1'b0;
   logic [3:0] e_an;
   logic [6:0] e_seg;
   logic       e_dp;
   bit         hi_zero;

   bcd_scan_display #(.TICK_DIV(TICK_DIV), .PRE_W(2)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .load_i      (load),
      .bcd_in_i    (bcd),
      .dp_in_i     (dpi),
      .blank_lz_i  (blz),
      .enable_i    (en),
      .seg_o       (seg),
      .dp_o        (dp),
      .an_o        (an),
      .digit_err_o (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pre = 0;
         m_idx = 0;
         for (int k = 0; k < 4; k++) m_dig[k] = 4'd0;
         m_dp  = '0;
         m_blz = 1'b0;
         m_err = 1'b0;
         exp_q.delete();
      end else begin
         if (m_pre == 0) begin
            e_an  = 4'b1111;
            e_seg = 7'b0;
            e_dp  = 1'b0;
         end else begin
            e_an = 4'b1111;
            e_an[m_idx] = 1'b0;
            hi_zero = 1'b1;
            for (int k = m_idx; k < 4; k++) if (m_dig[k] != 4'd0) hi_zero = 1'b0;
            e_seg = (m_blz && m_idx > 0 && hi_zero) ? 7'b0 : seg_tbl[m_dig[m_idx]];
            e_dp  = m_dp[m_idx];
         end
         if (load) begin
            for (int k = 0; k < 4; k++) m_dig[k] = bcd[4*k +: 4];
            m_dp  = dpi;
            m_blz = blz;
            m_err = 1'b0;
            for (int k = 0; k < 4; k++) if (m_dig[k] > 4'd9) m_err = 1'b1;
         end
         if (en) begin
            if (m_pre == TICK_DIV - 1) begin
               m_pre = 0;
               m_idx = (m_idx + 1) % 4;
            end else begin
               m_pre = m_pre + 1;
            end
         end
         exp_q.push_back({e_an, e_seg, e_dp, m_err});
      end
   end

   task automatic test_reset();
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({an, seg, dp, err} !== {4'b1111, 7'b0, 1'b0, 1'b0}) begin
         n_errors++;
         $display("FAIL reset_out got %b exp %b", {an, seg, dp, err}, {4'b1111, 7'b0, 2'b0});
      end
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++;
         if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL reset_sb_empty cycle %0d", i);
         end else if ({an, seg, dp, err} !== exp_q[0]) begin
            n_errors++;
            $display("FAIL reset_sb cycle %0d got %b exp %b", i, {an, seg, dp, err}, exp_q[0]);
         end
         if (exp_q.size() != 0) void'(exp_q.pop_front());
         n_checks++;
         if (an !== 4'b1111) begin
            n_errors++;
            $display("FAIL reset_idle_an cycle %0d got %b exp 1111", i, an);
         end
      end
   endtask

   task automatic test_scan();
      logic [6:0] lit [4];
      logic [3:0] x_an;
      logic [6:0] x_seg;
      lit = '{7'b1100110, 7'b1001111, 7'b1011011, 7'b0000110};
      bcd = 16'h1234; dpi = 4'b0000; blz = 1'b0; load = 1'b1; en = 1'b1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         n_checks++;
         if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL scan_sb_empty cycle %0d", i);
         end else if ({an, seg, dp, err} !== exp_q[0]) begin
            n_errors++;
            $display("FAIL scan_sb cycle %0d got %b exp %b", i, {an, seg, dp, err}, exp_q[0]);
         end
         if (exp_q.size() != 0) void'(exp_q.pop_front());
         x_an  = (i % 4 == 0) ? 4'b1111 : ~(4'b0001 << (i / 4));
         x_seg = (i % 4 == 0) ? 7'b0 : lit[i / 4];
         n_checks++;
         if (an !== x_an || seg !== x_seg) begin
            n_errors++;
            $display("FAIL scan_slot cycle %0d got an=%b seg=%b exp an=%b seg=%b", i, an, seg, x_an, x_seg);
         end
         load = 1'b0;
      end
   endtask

   task automatic test_blank();
      logic [6:0] lit [4];
      logic [3:0] x_an;
      logic [6:0] x_seg;
      lit = '{7'b0111111, 7'b0000111, 7'b0000000, 7'b0000000};
      bcd = 16'h0070; dpi = 4'b0000; blz = 1'b1; load = 1'b1; en = 1'b1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         n_checks++;
         if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL blank_sb_empty cycle %0d", i);
         end else if ({an, seg, dp, err} !== exp_q[0]) begin
            n_errors++;
            $display("FAIL blank_sb cycle %0d got %b exp %b", i, {an, seg, dp, err}, exp_q[0]);
         end
         if (exp_q.size() != 0) void'(exp_q.pop_front());
         x_an  = (i % 4 == 0) ? 4'b1111 : ~(4'b0001 << (i / 4));
         x_seg = (i % 4 == 0) ? 7'b0 : lit[i / 4];
         n_checks++;
         if (an !== x_an || seg !== x_seg) begin
            n_errors++;
            $display("FAIL blank_slot cycle %0d got an=%b seg=%b exp an=%b seg=%b", i, an, seg, x_an, x_seg);
         end
         load = 1'b0;
      end
   endtask

   task automatic test_err();
      bcd = 16'h00A5; dpi = 4'b0000; blz = 1'b0; load = 1'b1; en = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         n_checks++;
         if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL err_sb_empty cycle %0d", i);
         end else if ({an, seg, dp, err} !== exp_q[0]) begin
            n_errors++;
            $display("FAIL err_sb cycle %0d got %b exp %b", i, {an, seg, dp, err}, exp_q[0]);
         end
         if (exp_q.size() != 0) void'(exp_q.pop_front());
         if (i == 0 || i == 15) begin
            n_checks++;
            if (err !== 1'b1) begin
               n_errors++;
               $display("FAIL err_set cycle %0d got %b exp 1", i, err);
            end
         end
         if (i >= 5 && i <= 7) begin
            n_checks++;
            if (an !== 4'b1101 || seg !== 7'b1111001) begin
               n_errors++;
               $display("FAIL err_digit1 cycle %0d got an=%b seg=%b exp an=1101 seg=1111001", i, an, seg);
            end
         end
         if (i == 16) begin
            n_checks++;
            if (err !== 1'b0) begin
               n_errors++;
               $display("FAIL err_clear got %b exp 0", err);
            end
         end
         load = 1'b0;
         if (i == 15) begin
            bcd  = 16'h0005;
            load = 1'b1;
         end
      end
   endtask

   task automatic test_hold();
      bit found;
      en = 1'b1;
      found = 1'b0;
      for (int c = 0; c < 40 && !found; c++) begin
         if (m_pre == 1 && m_idx == 1) found = 1'b1;
         else begin
            @(negedge clk);
            n_checks++;
            if (exp_q.size() == 0) begin
               n_errors++;
               $display("FAIL hold_sb_empty wait %0d", c);
            end else if ({an, seg, dp, err} !== exp_q[0]) begin
               n_errors++;
               $display("FAIL hold_sb wait %0d got %b exp %b", c, {an, seg, dp, err}, exp_q[0]);
            end
            if (exp_q.size() != 0) void'(exp_q.pop_front());
         end
      end
      n_checks++;
      if (!found) begin
         n_errors++;
         $display("FAIL hold_align got timeout exp index1");
      end
      en = 1'b0;
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         n_checks++;
         if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL hold_sb_empty cycle %0d", i);
         end else if ({an, seg, dp, err} !== exp_q[0]) begin
            n_errors++;
            $display("FAIL hold_sb cycle %0d got %b exp %b", i, {an, seg, dp, err}, exp_q[0]);
         end
         if (exp_q.size() != 0) void'(exp_q.pop_front());
         n_checks++;
         if (an !== ((i == 13) ? 4'b1111 : 4'b1101)) begin
            n_errors++;
            $display("FAIL hold_an cycle %0d got %b exp %b", i, an, (i == 13) ? 4'b1111 : 4'b1101);
         end
         if (i == 9) en = 1'b1;
      end
   endtask

   task automatic test_wrap_load();
      bit found;
      en = 1'b1;
      found = 1'b0;
      for (int c = 0; c < 40 && !found; c++) begin
         if (m_pre == 3 && m_idx == 1) found = 1'b1;
         else begin
            @(negedge clk);
            n_checks++;
            if (exp_q.size() == 0) begin
               n_errors++;
               $display("FAIL wrap_sb_empty wait %0d", c);
            end else if ({an, seg, dp, err} !== exp_q[0]) begin
               n_errors++;
               $display("FAIL wrap_sb wait %0d got %b exp %b", c, {an, seg, dp, err}, exp_q[0]);
            end
            if (exp_q.size() != 0) void'(exp_q.pop_front());
         end
      end
      n_checks++;
      if (!found) begin
         n_errors++;
         $display("FAIL wrap_align got timeout exp pre3 index1");
      end
      bcd = 16'h9999; dpi = 4'b0100; blz = 1'b0; load = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++;
         if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL wrap_sb_empty cycle %0d", i);
         end else if ({an, seg, dp, err} !== exp_q[0]) begin
            n_errors++;
            $display("FAIL wrap_sb cycle %0d got %b exp %b", i, {an, seg, dp, err}, exp_q[0]);
         end
         if (exp_q.size() != 0) void'(exp_q.pop_front());
         load = 1'b0;
         if (i == 1) begin
            n_checks++;
            if (an !== 4'b1111 || seg !== 7'b0) begin
               n_errors++;
               $display("FAIL wrap_ghost got an=%b seg=%b exp an=1111 seg=0000000", an, seg);
            end
         end
         if (i == 2) begin
            n_checks++;
            if (an !== 4'b1011 || seg !== 7'b1101111 || dp !== 1'b1) begin
               n_errors++;
               $display("FAIL wrap_first_lit got an=%b seg=%b dp=%b exp an=1011 seg=1101111 dp=1", an, seg, dp);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      load = 1'b1;
      for (int i = 0; i < 48; i++) begin
         bcd = 16'($urandom_range(0, 65535));
         if ($urandom_range(0, 1) == 1) bcd = 16'h0000 | 16'($urandom_range(0, 9));
         dpi = 4'($urandom_range(0, 15));
         blz = 1'($urandom_range(0, 1));
         en  = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         n_checks++;
         if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL b2b_sb_empty cycle %0d", i);
         end else if ({an, seg, dp, err} !== exp_q[0]) begin
            n_errors++;
            $display("FAIL b2b_sb cycle %0d got %b exp %b", i, {an, seg, dp, err}, exp_q[0]);
         end
         if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      load = 1'b0;
      en = 1'b1;
   endtask

   task automatic test_reset_mid();
      bit found;
      bcd = 16'hA123; dpi = 4'b0000; blz = 1'b0; load = 1'b1; en = 1'b1;
      found = 1'b0;
      for (int c = 0; c < 40 && !found; c++) begin
         @(negedge clk);
         n_checks++;
         if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL rmid_sb_empty wait %0d", c);
         end else if ({an, seg, dp, err} !== exp_q[0]) begin
            n_errors++;
            $display("FAIL rmid_sb wait %0d got %b exp %b", c, {an, seg, dp, err}, exp_q[0]);
         end
         if (exp_q.size() != 0) void'(exp_q.pop_front());
         load = 1'b0;
         if (m_pre == 2 && m_idx == 2) found = 1'b1;
      end
      n_checks++;
      if (!found || an !== 4'b1011 || err !== 1'b1) begin
         n_errors++;
         $display("FAIL rmid_pre got an=%b err=%b found=%0d exp an=1011 err=1 found=1", an, err, found);
      end
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({an, seg, dp, err} !== {4'b1111, 7'b0, 1'b0, 1'b0}) begin
         n_errors++;
         $display("FAIL rmid_async got %b exp %b", {an, seg, dp, err}, {4'b1111, 7'b0, 2'b0});
      end
      en = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_checks++;
         if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL rmid_sb_empty cycle %0d", i);
         end else if ({an, seg, dp, err} !== exp_q[0]) begin
            n_errors++;
            $display("FAIL rmid_sb cycle %0d got %b exp %b", i, {an, seg, dp, err}, exp_q[0]);
         end
         if (exp_q.size() != 0) void'(exp_q.pop_front());
         n_checks++;
         if (an !== ((i == 3 || i == 4) ? 4'b1110 : 4'b1111)) begin
            n_errors++;
            $display("FAIL rmid_restart cycle %0d got %b exp %b", i, an, (i >= 3) ? 4'b1110 : 4'b1111);
         end
         if (i == 1) en = 1'b1;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_scan();
      test_blank();
      test_err();
      test_hold();
      test_wrap_load();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/bcd_scan_display.md
BCD_SCAN_DISPLAY -- requirements
Module: bcd_scan_display

Interface
REQ-001 Parameter TICK_DIV, default 50000, SHALL set clock cycles per digit slot; legal range 2..65535.
REQ-002 Parameter PRE_W, default 16, SHALL set the prescaler width and SHALL satisfy 2**PRE_W >= TICK_DIV.
REQ-003 clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  SHALL be the asynchronous, active-low reset (0 = reset asserted).
REQ-005 load  in  1  SHALL capture bcd_in, dp_in and blank_lz into the shadow register when high at a clock edge.
REQ-006 bcd_in  in  16  SHALL carry four BCD digits; [3:0] is digit0 (least significant), [15:12] is digit3. It is fed by cascaded mod-10 counters.
REQ-007 dp_in  in  4  SHALL carry per-digit decimal-point enables; bit k belongs to digit k.
REQ-008 blank_lz  in  1  SHALL enable leading-zero blanking.
REQ-009 enable  in  1  SHALL allow prescaler and scan advance when high.
REQ-010 seg  out  7  SHALL drive active-high segments, ordered {g,f,e,d,c,b,a}, with seg[0]=a.
REQ-011 dp  out  1  SHALL drive the active-high decimal point of the lit digit.
REQ-012 an  out  4  SHALL drive active-low anode selects, one-hot; bit k selects digit k.
REQ-013 digit_err  out  1  SHALL flag that the shadow register holds a non-BCD nibble.

Function
REQ-014 The prescaler SHALL count 0..TICK_DIV-1 while enable=1 and SHALL wrap to 0 after TICK_DIV-1.
REQ-015 At the wrap edge, the 2-bit scan index SHALL advance mod 4 (3->0).
REQ-016 While enable=0, the prescaler and index SHALL hold, and outputs SHALL keep refreshing from the shadow register.
REQ-017 seg, dp and an SHALL be registered outputs, computed each edge from the pre-edge index, prescaler and shadow values (1-cycle latency).
REQ-018 Ghost suppression: when the pre-edge prescaler equals 0, an SHALL load 4'b1111, seg SHALL load 0 and dp SHALL load 0.
REQ-019 Otherwise, an SHALL load the one-hot-low code of the index (index 2 -> 4'b1011).
REQ-020 Segment decode for digits 0..9 SHALL be: 0111111, 0000110, 1011011, 1001111, 1100110, 1101101, 1111101, 0000111, 1111111, 1101111.
REQ-021 Nibbles 10..15 SHALL decode to "E" = 1111001.
REQ-022 Leading-zero blanking (shadow blank_lz=1): digit k (k=3..1) SHALL show seg=0 and dp=dp_in[k] when it and all higher digits are 0.
REQ-023 Digit0 SHALL never be blanked.
REQ-024 digit_err SHALL become 1 at a load edge when any captured nibble >9, and SHALL become 0 at a load edge when all captured nibbles are <=9; it SHALL hold otherwise.
REQ-025 When load coincides with an index wrap, the new index SHALL use the new shadow data from the next edge; no mixed-old/new digit SHALL appear.
REQ-026 When load is held high continuously, the block SHALL recapture every cycle.

Reset
REQ-027 On rst=0, the block SHALL immediately and asynchronously clear the shadow (digits 0, dp 0, blank_lz 0), prescaler=0, index=0, seg=0, dp=0, an=4'b1111 and digit_err=0, regardless of clock or operation in progress.
REQ-028 After rst rises, the first prescaler increment SHALL occur at the first rising edge with enable=1.

Verification (TICK_DIV=4)
REQ-029 Assert rst=0 mid-scan with index=2 -> an=1111, seg=0, digit_err=0 immediately, without a clock edge.
REQ-030 Load 16'h1234, blank_lz=0, enable=1 -> the cycle sequence SHALL show an 1111, 1110, 1110, 1110 with seg=1100110, then the same pattern with an=1101 and seg=1001111, continuing through digit3 ("1").
REQ-031 Load 16'h0070, blank_lz=1 -> digit3 and digit2 slots SHALL show seg=0000000; digit1 SHALL show 0000111; digit0 SHALL show 0111111.
REQ-032 Load 16'h00A5 -> digit_err=1 after the load edge and the digit1 slot SHALL show seg=1111001; a later load of 16'h0005 SHALL return digit_err to 0.
REQ-033 Drop enable for 10 cycles at index 1 -> an SHALL stay 1101 throughout; on re-enable, the prescaler SHALL resume from its held value.
REQ-034 Pulse load with 16'h9999, dp_in=4'b0100 on the wrap edge into index 2 -> the first lit cycle of that slot SHALL show seg=1101111, dp=1.
